mpc_in_router: RTL
==================

Name: mpc_in_router

Overview:
- Input-direction companion of the 2x2 pad-output multiplexer.
- Takes north/west/east pad inputs, synchronises them to clk, and routes them to the four chip macros (_0.._3) according to configuration.
- A change of configuration runs a blanking sequence, so no macro sees a glitch or a stale mapping during reconfiguration.
- Sits between the IO pad ring and the macro input pins, alongside the output mux.

Parameters:
- SYNC_STAGES, 2, flops per pad-input synchroniser chain (legal 2..4).
- BLANK_CYCLES, 4, cycles all macro inputs are held at 0 after a configuration change (legal 1..255).

Ports:
- clk  input  1  block clock
- rst_n  input  1  asynchronous active-low reset
- configuration  input  4  routing configuration (quasi-static, asynchronous to clk)
- north_i  input  10  north pad inputs
- west_i  input  14  west pad inputs
- east_i  input  14  east pad inputs
- north_i_0..north_i_3  output  10 each  north inputs to macros 0..3
- west_i_0..west_i_3  output  14 each  west inputs to macros 0..3
- east_i_0..east_i_3  output  14 each  east inputs to macros 0..3
- cfg_busy  output  1  high while blanking or settling a new configuration
- cfg_active  output  4  configuration currently applied

Behaviour:
- Reset (rst_n low, async):
  - all macro outputs = 0, cfg_busy = 1, cfg_active = 0, synchroniser flops = 0, FSM = BLANK, counter = BLANK_CYCLES-1.
- Synchronisation:
  - north_i/west_i/east_i each pass through a SYNC_STAGES flop chain.
  - configuration passes through its own SYNC_STAGES chain to give cfg_sync.
- Data latency: pad input to macro output = SYNC_STAGES+1 cycles. The output stage is registered.
- FSM states:
  - RUN: outputs routed per cfg_active; cfg_busy = 0. If cfg_sync != cfg_active: go to BLANK, load counter = BLANK_CYCLES-1, and drive all outputs 0 from the next cycle.
  - BLANK: all outputs 0, cfg_busy = 1. Counter decrements each cycle. At counter == 0, go to SETTLE.
  - SETTLE: cfg_active <= cfg_sync, outputs still 0, cfg_busy = 1. Go to RUN.
- Configuration change during BLANK: counter reloads to BLANK_CYCLES-1, so the full blank restarts.
- Configuration change during SETTLE: the value captured in SETTLE is used; RUN then detects the mismatch on its first cycle and re-enters BLANK.
- Routing in RUN (mode = cfg_active[3:2], sel = cfg_active[1:0]):
  - mode 0 (single): macro sel receives north/west/east; the other three macros receive 0.
  - mode 1 (row pair, row r = cfg_active[0]):
    - west -> macro 2r; east -> macro 2r+1.
    - north[4:0] -> macro 2r bits [4:0]; north[9:5] -> macro 2r+1 bits [9:5].
    - Unused bits and the other row get 0.
  - mode 2 (broadcast): all four macros receive all pad inputs.
  - mode 3 (reserved): all outputs 0; cfg_busy = 0.
- After reset: first mapping applied BLANK_CYCLES+1 cycles after release (configuration settled), plus SYNC_STAGES for the config sync.

Optional Feature:
- MPC_IN_GLITCH_FILTER_EN
- When defined: each synchronised pad bit passes through an extra filter.
  - The filtered value updates only when two consecutive synchronised samples agree.
  - Otherwise it holds its previous value.
  - Data latency becomes SYNC_STAGES+2. Filter flops reset to 0.
- When undefined: no filter; latency SYNC_STAGES+1.

Test Plan:
- Reset then configuration=4'b0010 (mode 0, sel 2), west_i=14'h1ABC.
  - Expect cfg_busy falls and cfg_active=4'h2.
  - west_i_2=14'h1ABC exactly 3 cycles after the input change (SYNC_STAGES=2); west_i_0/1/3=0.
- Mode 1 row 1 (configuration=4'b0101), north_i=10'h3FF, east_i=14'h0F0F.
  - north_i_2=10'h01F, north_i_3=10'h3E0, east_i_3=14'h0F0F, east_i_2=0, macros 0/1 all 0.
- In RUN, change configuration 4'h8 -> 4'h1.
  - After sync, outputs go 0 for BLANK_CYCLES+1 cycles with cfg_busy=1, then macro 1 receives the inputs.
- Change configuration again on the 2nd BLANK cycle.
  - Blank counter restarts: total blank = 2+BLANK_CYCLES+1 cycles; the final mapping is the second value.
- Assert rst_n low mid-RUN in broadcast mode.
  - All outputs 0 immediately (async); cfg_active=0; cfg_busy=1 until the re-blank completes.
- With MPC_IN_GLITCH_FILTER_EN: a 1-cycle pulse on north_i[0] produces no output change; a 2-cycle pulse reaches the output at latency 4.

Source files
------------

// File: rtl/mpc_in_router_if.sv
// Pad-side and macro-side signal bundle for mpc_in_router.
// master = pad ring / configuration source, slave = the router.
interface mpc_in_router_if;
  logic [3:0]  configuration;
  logic [9:0]  north_i;
  logic [13:0] west_i;
  logic [13:0] east_i;
  logic [9:0]  north_i_0, north_i_1, north_i_2, north_i_3;
  logic [13:0] west_i_0, west_i_1, west_i_2, west_i_3;
  logic [13:0] east_i_0, east_i_1, east_i_2, east_i_3;
  logic        cfg_busy;
  logic [3:0]  cfg_active;
  logic [1:0]  dbg_state;

  modport master (
    output configuration, north_i, west_i, east_i,
    input  north_i_0, north_i_1, north_i_2, north_i_3,
    input  west_i_0, west_i_1, west_i_2, west_i_3,
    input  east_i_0, east_i_1, east_i_2, east_i_3,
    input  cfg_busy, cfg_active, dbg_state
  );

  modport slave (
    input  configuration, north_i, west_i, east_i,
    output north_i_0, north_i_1, north_i_2, north_i_3,
    output west_i_0, west_i_1, west_i_2, west_i_3,
    output east_i_0, east_i_1, east_i_2, east_i_3,
    output cfg_busy, cfg_active, dbg_state
  );
endinterface

// File: rtl/mpc_in_router.sv
// Synchronises north/west/east pad inputs and routes them to four macros with blanked reconfiguration.
// Optional per-bit glitch filter on the synchronised pads: define MPC_IN_GLITCH_FILTER_EN.
module mpc_in_router #(
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  mpc_in_router_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BLANK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int         PW         = 38;
  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

  logic [SYNC_STAGES-1:0][PW-1:0] pad_sync;
  logic [SYNC_STAGES-1:0][3:0]    cfg_chain;
  logic [PW-1:0] pad_s;
  logic [PW-1:0] pad_f;
  logic [3:0]    cfg_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_sync  <= '0;
      cfg_chain <= '0;
    end else begin
      pad_sync[0]  <= {bus.north_i, bus.west_i, bus.east_i};
      cfg_chain[0] <= bus.configuration;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pad_sync[i]  <= pad_sync[i-1];
        cfg_chain[i] <= cfg_chain[i-1];
      end
    end
  end

  assign pad_s    = pad_sync[SYNC_STAGES-1];
  assign cfg_sync = cfg_chain[SYNC_STAGES-1];

`ifdef MPC_IN_GLITCH_FILTER_EN
  logic [PW-1:0] prev_q;
  logic [PW-1:0] filt_q;

  // A bit follows the pad only once two consecutive samples agree; otherwise it holds.
  assign pad_f = (~(pad_s ^ prev_q) & pad_s) | ((pad_s ^ prev_q) & filt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      filt_q <= '0;
    end else begin
      prev_q <= pad_s;
      filt_q <= pad_f;
    end
  end
`else
  assign pad_f = pad_s;
`endif

  logic [9:0]  pn;
  logic [13:0] pw;
  logic [13:0] pe;
  assign pn = pad_f[37:28];
  assign pw = pad_f[27:14];
  assign pe = pad_f[13:0];

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] cfg_active, cfg_active_next, cfg_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      cnt        <= BLANK_LOAD;
      cfg_active <= '0;
      cfg_seen   <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cfg_active <= cfg_active_next;
      cfg_seen   <= cfg_sync;
    end
  end

  // Any movement of the synchronised configuration while blanking restarts the full blank.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cfg_active_next = cfg_active;
    case (state)
      ST_RUN: begin
        if (cfg_sync != cfg_active) begin
          state_next = ST_BLANK;
          cnt_next   = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (cfg_sync != cfg_seen) begin
          cnt_next = BLANK_LOAD;
        end else if (cnt == 8'd0) begin
          state_next = ST_SETTLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ST_SETTLE: begin
        cfg_active_next = cfg_sync;
        state_next      = ST_RUN;
      end
      default: begin
        state_next = ST_BLANK;
        cnt_next   = BLANK_LOAD;
      end
    endcase
  end

  logic [3:0][9:0]  rn, out_n;
  logic [3:0][13:0] rw, out_w;
  logic [3:0][13:0] re, out_e;
  logic             row;

  assign row = cfg_active_next[0];

  // Routing follows the next state so the output register blanks in step with cfg_busy.
  always_comb begin
    rn = '0;
    rw = '0;
    re = '0;
    if (state_next == ST_RUN) begin
      case (cfg_active_next[3:2])
        2'd0: begin
          rn[cfg_active_next[1:0]] = pn;
          rw[cfg_active_next[1:0]] = pw;
          re[cfg_active_next[1:0]] = pe;
        end
        2'd1: begin
          rw[{row, 1'b0}] = pw;
          re[{row, 1'b1}] = pe;
          rn[{row, 1'b0}] = {5'b0, pn[4:0]};
          rn[{row, 1'b1}] = {pn[9:5], 5'b0};
        end
        2'd2: begin
          for (int m = 0; m < 4; m++) begin
            rn[m] = pn;
            rw[m] = pw;
            re[m] = pe;
          end
        end
        default: begin
          rn = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_n <= '0;
      out_w <= '0;
      out_e <= '0;
    end else begin
      out_n <= rn;
      out_w <= rw;
      out_e <= re;
    end
  end

  assign bus.north_i_0  = out_n[0];
  assign bus.north_i_1  = out_n[1];
  assign bus.north_i_2  = out_n[2];
  assign bus.north_i_3  = out_n[3];
  assign bus.west_i_0   = out_w[0];
  assign bus.west_i_1   = out_w[1];
  assign bus.west_i_2   = out_w[2];
  assign bus.west_i_3   = out_w[3];
  assign bus.east_i_0   = out_e[0];
  assign bus.east_i_1   = out_e[1];
  assign bus.east_i_2   = out_e[2];
  assign bus.east_i_3   = out_e[3];
  assign bus.cfg_busy   = (state != ST_RUN);
  assign bus.cfg_active = cfg_active;
  assign bus.dbg_state  = state;
endmodule
